// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller for an 8-bit R2R DAC and comparator.
// Resolves one bit per T_BIT clocks and returns the result over valid/ready.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  input  logic             ready
);

  localparam int T_BIT = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CW    = $clog2(T_BIT + 1);
  localparam int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [KW-1:0]          bit_q, bit_d;
  logic [WIDTH-1:0]       code_q, code_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cmp_sync;

  assign cmp_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d           = SETTLE;
          cnt_d             = '0;
          bit_d             = KW'(WIDTH - 1);
          code_d            = '0;
          code_d[WIDTH-1]   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(T_BIT - 1)) begin
          cnt_d         = '0;
          code_d[bit_q] = cmp_sync;
          // Next trial bit goes up on the same edge as this decision
          if (bit_q != '0) begin
            code_d[bit_q - KW'(1)] = 1'b1;
            bit_d                  = bit_q - KW'(1);
          end else begin
            res_d   = code_d;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (ready) begin
          state_d = IDLE;
          code_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dac_code = code_q;
  assign result   = res_q;
  assign sample   = (state_q == SAMPLE);
  assign busy     = (state_q != IDLE);
  assign valid    = (state_q == DONE);

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, time-based reference model,
// directed scenarios plus randomized conversions.
module tb_sar_adc_ctrl;

  localparam int TS  = 4;
  localparam int SYN = 2;
  localparam int TB  = TS + SYN;
  localparam int LAT = TS + 8 * TB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic       cmp;
  logic [7:0] vin = 8'h00;
  logic [7:0] dac_code, result;
  logic       sample, busy, valid;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  sar_adc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cmp      (cmp),
    .dac_code (dac_code),
    .sample   (sample),
    .busy     (busy),
    .result   (result),
    .valid    (valid),
    .ready    (ready)
  );

  always #50 clk = ~clk;

  assign cmp = (vin >= dac_code);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: elapsed clocks since the start edge decide everything.
  bit         m_run  = 1'b0;
  bit         m_done = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_code = 8'h00;
  logic [7:0] m_res  = 8'h00;
  logic [7:0] vd1 = 8'h00, vd2 = 8'h00;

  always @(posedge clk) begin
    vd1 <= vin;
    vd2 <= vd1;
  end

  function automatic logic [7:0] step(int t, logic [7:0] c, logic [7:0] v);
    logic [7:0] r;
    int k;
    r = c;
    if (t == TS) r = 8'h80;
    else if (t > TS && (t - TS) % TB == 0) begin
      k = 8 - (t - TS) / TB;
      if (v < c) r[k] = 1'b0;
      if (k > 0) r[k-1] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
      m_code <= 8'h00;
      m_res  <= 8'h00;
    end else if (m_done) begin
      if (ready) begin
        m_done <= 1'b0;
        m_code <= 8'h00;
      end
    end else if (m_run) begin
      m_t    <= m_t + 1;
      m_code <= step(m_t + 1, m_code, vd2);
      if (m_t + 1 == LAT) begin
        m_res  <= step(m_t + 1, m_code, vd2);
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (start) begin
      m_run <= 1'b1;
      m_t   <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_sample", int'(sample), int'(m_run && m_t < TS));
      chk("cyc_busy", int'(busy), int'(m_run || m_done));
      chk("cyc_valid", int'(valid), int'(m_done));
      chk("cyc_dac", int'(dac_code), int'(m_code));
      if (m_done) chk("cyc_result", int'(result), int'(m_res));
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        return;
      end
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic ack();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic conv(input logic [7:0] v, input int hold,
                      output logic [7:0] r);
    bit ok;
    @(negedge clk);
    vin = v;
    start = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    r = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    ack();
  endtask

  initial begin
    logic [7:0] r, r0, d0;
    logic [7:0] exp_seq [8];
    int early, unstable, c1, c2;
    bit ok;
    exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (3) @(negedge clk);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(valid), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: 0xA5 trial sequence and exact latency
    vin = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    early = 0;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      if (n >= TS && n < LAT && (n - TS) % TB == 0)
        chk($sformatf("t1_code%0d", (n - TS) / TB), int'(dac_code),
            int'(exp_seq[(n - TS) / TB]));
      if (n < LAT && valid) early++;
    end
    chk("t1_valid_early", early, 0);
    chk("t1_valid_lat", int'(valid), 1);
    chk("t1_result", int'(result), 8'hA5);
    ack();
    chk("t1_idle_valid", int'(valid), 0);
    chk("t1_idle_dac", int'(dac_code), 0);

    // 2: extremes
    conv(8'h00, 0, r);
    chk("t2_zero", int'(r), 8'h00);
    conv(8'hFF, 1, r);
    chk("t2_full", int'(r), 8'hFF);

    // 3: backpressure with ignored start pulses
    @(negedge clk);
    vin = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    r0 = result;
    d0 = dac_code;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      if (!valid || result != r0 || dac_code != d0) unstable++;
    end
    start = 1'b0;
    chk("t3_stable", unstable, 0);
    chk("t3_result", int'(r0), 8'h3C);
    ack();
    chk("t3_valid_drop", int'(valid), 0);
    chk("t3_busy_drop", int'(busy), 0);

    // 4: back-to-back with start and ready held
    @(negedge clk);
    vin = 8'h10;
    start = 1'b1;
    ready = 1'b1;
    wait_valid(ok);
    c1 = cyc;
    chk("t4_res0", int'(result), 8'h10);
    vin = 8'hF0;
    @(negedge clk);
    chk("t4_drop", int'(valid), 0);
    wait_valid(ok);
    c2 = cyc;
    chk("t4_res1", int'(result), 8'hF0);
    chk("t4_period", c2 - c1, 54);
    start = 1'b0;
    @(negedge clk);
    ready = 1'b0;

    // 5: reset mid-conversion
    @(negedge clk);
    vin = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_dac", int'(dac_code), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(valid), 0);
    chk("t5_sample", int'(sample), 0);
    chk("t5_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    conv(8'h5A, 0, r);
    chk("t5_after", int'(r), 8'h5A);

    // 6: late input change inside the synchronizer window of bit 7
    @(negedge clk);
    vin = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (TS + TB - SYN) @(negedge clk);
    vin = 8'h00;
    repeat (SYN) @(negedge clk);
    vin = 8'h80;
    wait_valid(ok);
    chk("t6_hi", int'(result), 8'h80);
    ack();
    @(negedge clk);
    vin = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (TS + TB - SYN) @(negedge clk);
    vin = 8'hFF;
    repeat (SYN) @(negedge clk);
    vin = 8'h7F;
    wait_valid(ok);
    chk("t6_lo", int'(result), 8'h7F);
    ack();

    // Randomized conversions with random backpressure
    for (int i = 0; i < 25; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      conv(v, $urandom_range(0, 4), r);
      chk("rand_result", int'(r), int'(v));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
